alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the EX stage.
//  Accepts one M-extension op. Runs a radix-2 shift-add (MUL*) or restoring-subtract (DIV*/REM*) loop for XLEN cycles.
//  Holds the pipeline stall line until the result is ready. Also handles pipeline flush.
// PARAMETERS
//  XLEN      32   operand/result width
//  CNT_W     6    iteration counter width, >= clog2(XLEN)+1
// PORTS
//  CPU_CLK    in   1     core clock, rising edge
//  CPU_RST_N  in   1     asynchronous, active-low reset
//  start      in   1     EX holds an M-op this cycle; sampled only in IDLE
//  flush      in   1     squash the in-flight op (branch/jump kill)
//  funct3     in   3     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  operand1   in   XLEN  rs1 value
//  operand2   in   XLEN  rs2 value
//  busy       out  1     op in flight (CALC or FIX)
//  stall      out  1     to hazard unit: freeze IF/ID/EX while the op is pending
//  out_valid  out  1     one-cycle pulse: result holds final value
//  result     out  XLEN  final product/quotient/remainder
// BEHAVIOUR
//  Reset (async, CPU_RST_N=0): state=IDLE, busy=0, stall=0, out_valid=0, result=0, counter=0, internal regs=0.
//  FSM states IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: when start=1 & flush=0, latch funct3 and magnitudes |op1|,|op2|.
//     Signedness follows funct3: MULHSU treats op2 as unsigned; MULHU, DIVU, REMU are unsigned.
//     Record sign flags, set counter=XLEN, then go to CALC.
//   CALC: one iteration per cycle; counter decrements; at counter==1 go to FIX.
//     Multiply: 2*XLEN accumulator, add multiplicand if LSB of multiplier, shift right.
//     Divide: shift {rem,quo} left 1, trial subtract divisor, set quotient bit if result is non-negative.
//   FIX: apply sign correction.
//     Product negated if the two sign flags differ.
//     Quotient negated if the signs differ; remainder takes the dividend's sign.
//     Select the low XLEN bits (MUL) or high XLEN bits (MULH/MULHSU/MULHU). Go to DONE.
//   DONE: out_valid=1 for exactly this cycle; result is registered and stable. Go to IDLE.
//  Latency: start accepted in cycle 0 -> out_valid in cycle XLEN+2 (34 for XLEN=32).
//  stall = (IDLE & start & ~flush) | CALC | FIX. It is low in DONE, so EX advances on the out_valid cycle.
//  busy = CALC | FIX.
//  Special cases are resolved in IDLE and jump straight to DONE (latency 1):
//   Divide by zero: DIV/DIVU -> all ones; REM/REMU -> operand1.
//   Signed overflow (0x80000000 / -1): DIV -> 0x80000000; REM -> 0.
//  flush in any non-IDLE state: return to IDLE next edge; out_valid stays 0; result unchanged.
//  flush and start together in IDLE: the op is not accepted.
//  start outside IDLE is ignored; no queueing.
//  result keeps its last value until the next DONE.
//  Reset asserted mid-operation: abort immediately to reset values; no pulse after release.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   A multiply with either operand zero completes via IDLE -> DONE, latency 1, result 0.
//   A divide with |op1| < |op2| completes via IDLE -> DONE, latency 1.
//     Quotient 0; remainder = operand1 (DIV/DIVU); REM/REMU = operand1.
//  Not defined: these cases run the full XLEN+2 cycles with identical results.
//  The divide-by-zero and overflow shortcuts are always present.
// STRUCTURE
//  Parameters.v gets:
//   `MUL..`REMU funct3 encodings.
//   FSM state encodings `MD_IDLE/`MD_CALC/`MD_FIX/`MD_DONE (2-bit).
//   `MD_LATENCY = XLEN+2.
//  One sub-module, muldiv_negate: combinational conditional two's-complement negate, used for operand magnitude and for FIX.
//  The FSM, counter and accumulator stay in this module.
//  The hazard unit ORs stall into its existing stall logic.
//  WB muxes result vs AluOut on an is_mdu decode bit.
// TESTING
//  1 MUL 7 x -3: start with op1=7, op2=0xFFFFFFFD -> out_valid at cycle 34, result=0xFFFFFFEB; stall high cycles 0-33.
//  2 MULHU / MULH 0xFFFFFFFF x 0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000.
//  3 DIV 0x80000000 / 0xFFFFFFFF:
//     -> result 0x80000000 at cycle 1, REM -> 0.
//     DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 10.
//  4 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 100/7 -> 2; all at cycle 34.
//  5 flush at cycle 10 of a DIV:
//     -> IDLE at cycle 11, no out_valid, result unchanged.
//     A new start at cycle 11 -> valid at cycle 45.
//     Reset pulse at cycle 5 -> all outputs 0, no out_valid.
//  6 With MULDIV_EARLY_OUT_EN: MUL 0 x 5 -> result 0 at cycle 1; DIVU 3/9 -> 0 at cycle 1.
//     Without it: both at cycle 34.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_muldiv_seq_pkg
//  Purpose : Shared definitions for the iterative RV32M multiply/divide
//            sequencer: funct3 operation codes, FSM state type and small
//            decode helpers for operand signedness.
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package alu_muldiv_seq_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // rs1 is treated as signed for every op except the fully unsigned ones.
  // MUL is listed as signed: its low half is identical either way.
  function automatic logic op1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is signed for MUL/MULH/DIV/REM; MULHSU takes rs2 as unsigned.
  function automatic logic op2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Within the divide family, funct3[1] selects remainder over quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage : alu_muldiv_seq_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module  : alu_muldiv_seq_if
//  Purpose : Request/response bundle between the EX stage and the
//            multiply/divide sequencer.
//  Signals : start, flush, funct3, operand1, operand2  (EX -> sequencer)
//            busy, stall, out_valid, result            (sequencer -> EX)
//  Modports: master = EX stage side, slave = sequencer side
//  Revision: 1.0  initial release
// ============================================================================
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            busy;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, operand1, operand2,
    input  busy, stall, out_valid, result
  );

  modport slave (
    input  start, flush, funct3, operand1, operand2,
    output busy, stall, out_valid, result
  );
endinterface : alu_muldiv_seq_if
`default_nettype wire

// File: rtl/alu_muldiv_seq_negate.sv
`default_nettype none
// ============================================================================
//  Module  : alu_muldiv_seq_negate
//  Purpose : Combinational conditional two's-complement negate. Used to
//            form operand magnitudes on entry and to restore result signs
//            after the unsigned iteration loop.
//  Ports   : value  in  WIDTH  input word
//            negate in  1      1 = return -value, 0 = pass through
//            result out WIDTH  conditionally negated word
//  Revision: 1.0  initial release
// ============================================================================
module alu_muldiv_seq_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule : alu_muldiv_seq_negate
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module  : alu_muldiv_seq
//  Purpose : Iterative RV32M multiply/divide sequencer sitting beside the
//            single-cycle ALU in EX. One radix-2 iteration per cycle:
//            shift-add for MUL*, restoring subtract for DIV*/REM*.
//            Holds the pipeline stall line until the result is ready and
//            honours pipeline flush.
//  Ports   : CPU_CLK    in   core clock, rising edge
//            CPU_RST_N  in   asynchronous active-low reset
//            md         slave modport of alu_muldiv_seq_if
//              start/flush/funct3/operand1/operand2 in
//              busy/stall/out_valid/result           out
//  Options : MULDIV_EARLY_OUT_EN  when defined, multiplies with a zero
//            operand and divides with |op1| < |op2| finish in one cycle.
//  Revision: 1.0  initial release
// ============================================================================
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST_N,
  alu_muldiv_seq_if.slave    md
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  md_state_t         state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        op;
  logic              sign_a;       // rs1 was negative and signed
  logic              sign_b;       // rs2 was negative and signed
  logic [2*XLEN-1:0] acc;          // MUL: {partial, multiplier}; DIV: {rem, quo}
  logic [XLEN-1:0]   mcand;        // multiplicand or divisor magnitude
  logic [XLEN-1:0]   result_q;

  // --------------------------------------------------------------------------
  // Request decode in IDLE
  // --------------------------------------------------------------------------
  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept;
  logic            div_zero;
  logic            div_ovf;
  logic            shortcut;
  logic [XLEN-1:0] shortcut_res;

  assign neg1   = op1_is_signed(md.funct3) & md.operand1[XLEN-1];
  assign neg2   = op2_is_signed(md.funct3) & md.operand2[XLEN-1];
  assign accept = (state == MD_IDLE) & md.start & ~md.flush;

  alu_muldiv_seq_negate #(.WIDTH(XLEN)) u_mag1 (
    .value  (md.operand1),
    .negate (neg1),
    .result (mag1)
  );

  alu_muldiv_seq_negate #(.WIDTH(XLEN)) u_mag2 (
    .value  (md.operand2),
    .negate (neg2),
    .result (mag2)
  );

  assign div_zero = is_div_op(md.funct3) & (md.operand2 == '0);
  assign div_ovf  = ((md.funct3 == F3_DIV) || (md.funct3 == F3_REM)) &
                    (md.operand1 == MOST_NEG) & (md.operand2 == '1);

  // Cases whose answer is known without iterating; they go straight to DONE.
  always_comb begin
    shortcut     = 1'b0;
    shortcut_res = '0;
    if (div_zero) begin
      shortcut     = 1'b1;
      shortcut_res = is_rem_op(md.funct3) ? md.operand1 : '1;
    end else if (div_ovf) begin
      // Quotient wraps to the most negative value; remainder is zero.
      shortcut     = 1'b1;
      shortcut_res = is_rem_op(md.funct3) ? '0 : MOST_NEG;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div_op(md.funct3) &&
             ((md.operand1 == '0) || (md.operand2 == '0))) begin
      shortcut     = 1'b1;
      shortcut_res = '0;
    end else if (is_div_op(md.funct3) && (mag1 < mag2)) begin
      // Quotient is zero and the remainder is the dividend, sign included.
      shortcut     = 1'b1;
      shortcut_res = is_rem_op(md.funct3) ? md.operand1 : '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // One multiply iteration: conditional add into the upper half, then a
  // right shift that carries the add's carry-out into the top bit.
  // --------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                    (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // --------------------------------------------------------------------------
  // One restoring-divide iteration. The shifted partial remainder needs one
  // extra bit; since it is always below twice the divisor, the sign of the
  // (XLEN+1)-bit difference is the borrow.
  // --------------------------------------------------------------------------
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     trial;
  logic              fits;
  logic [2*XLEN-1:0] div_next;

  assign rem_sh   = acc[2*XLEN-1:XLEN-1];
  assign trial    = rem_sh - {1'b0, mcand};
  assign fits     = ~trial[XLEN];
  assign div_next = {(fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc[XLEN-2:0], fits};

  // --------------------------------------------------------------------------
  // Sign restoration and result selection for FIX
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   quo_fixed;
  logic [XLEN-1:0]   rem_fixed;
  logic [XLEN-1:0]   fix_res;

  alu_muldiv_seq_negate #(.WIDTH(2*XLEN)) u_fix_prod (
    .value  (acc),
    .negate (sign_a ^ sign_b),
    .result (prod_fixed)
  );

  alu_muldiv_seq_negate #(.WIDTH(XLEN)) u_fix_quo (
    .value  (acc[XLEN-1:0]),
    .negate (sign_a ^ sign_b),
    .result (quo_fixed)
  );

  // Remainder follows the dividend's sign only.
  alu_muldiv_seq_negate #(.WIDTH(XLEN)) u_fix_rem (
    .value  (acc[2*XLEN-1:XLEN]),
    .negate (sign_a),
    .result (rem_fixed)
  );

  always_comb begin
    fix_res = '0;
    case (op)
      F3_MUL:                       fix_res = prod_fixed[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fixed[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_fixed;
      F3_REM, F3_REMU:              fix_res = rem_fixed;
      default:                      fix_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state    <= MD_IDLE;
      counter  <= '0;
      op       <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (accept) begin
            op     <= md.funct3;
            sign_a <= neg1;
            sign_b <= neg2;
            if (shortcut) begin
              result_q <= shortcut_res;
              state    <= MD_DONE;
            end else begin
              acc     <= {{XLEN{1'b0}}, mag1};
              mcand   <= mag2;
              counter <= CNT_W'(XLEN);
              state   <= MD_CALC;
            end
          end
        end

        MD_CALC: begin
          if (md.flush) begin
            state <= MD_IDLE;
          end else begin
            acc     <= is_div_op(op) ? div_next : mul_next;
            counter <= counter - CNT_W'(1);
            // The iteration performed at count 1 is the last of XLEN.
            if (counter == CNT_W'(1)) begin
              state <= MD_FIX;
            end
          end
        end

        MD_FIX: begin
          if (md.flush) begin
            state <= MD_IDLE;
          end else begin
            result_q <= fix_res;
            state    <= MD_DONE;
          end
        end

        MD_DONE: begin
          state <= MD_IDLE;
        end

        default: begin
          state <= MD_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. busy/out_valid decode straight from the state flops. stall also
  // covers the acceptance cycle so EX freezes on the very edge that latches
  // the request; it drops in DONE so EX advances with the result.
  // --------------------------------------------------------------------------
  assign md.busy      = (state == MD_CALC) || (state == MD_FIX);
  assign md.stall     = accept | md.busy;
  assign md.out_valid = (state == MD_DONE);
  assign md.result    = result_q;

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_muldiv_seq
//  Purpose : Self-checking bench for alu_muldiv_seq: directed vector table,
//            randomized ops against an arithmetic reference model, and
//            hand-written flush / reset / start-while-busy sequences.
//  Revision: 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 34;
`endif
  localparam int FULL = 34;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_muldiv_seq_if #(.XLEN(32)) mif ();

  alu_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .CPU_CLK   (clk),
    .CPU_RST_N (rst_n),
    .md        (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint     sa = longint'($signed(a));
    longint     sb = longint'($signed(b));
    longint     ua = longint'({32'b0, a});
    longint     ub = longint'({32'b0, b});
    int         ia = a;
    int         ib = b;
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFFFFFF :
                ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib));
      3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (f3 == 3'd4) || (f3 == 3'd6);
    longint ma = (sgn && a[31]) ? -longint'($signed(a)) : longint'({32'b0, a});
    longint mb = (sgn && b[31]) ? -longint'($signed(b)) : longint'({32'b0, b});
    if (f3[2] && b == 0) return 1;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2] && (a == 0 || b == 0)) return 1;
    if (f3[2] && ma < mb) return 1;
`else
    if (ma < 0 || mb < 0) return 0;   // unreachable: magnitudes are non-negative
`endif
    return FULL;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'($urandom_range(0, 15));
      2: return -32'($urandom_range(1, 15));
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and counts edges until out_valid. hs_ok reports whether
  // stall/busy followed the expected shape throughout. poke>0 re-asserts
  // start with a different op at that cycle to confirm it is ignored.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit no_wait, input int poke,
                        output logic [31:0] res, output int lat, output bit hs_ok);
    hs_ok = 1'b1;
    lat   = 0;
    res   = '0;
    if (!no_wait) @(negedge clk);
    mif.start    = 1'b1;
    mif.flush    = 1'b0;
    mif.funct3   = f3;
    mif.operand1 = a;
    mif.operand2 = b;
    #1;
    if (mif.stall !== 1'b1 || mif.busy !== 1'b0 || mif.out_valid !== 1'b0) hs_ok = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) mif.start = 1'b0;
      if (poke > 0 && n == poke) begin
        mif.start    = 1'b1;
        mif.funct3   = F3_MUL;
        mif.operand1 = 32'h1234;
        mif.operand2 = 32'h5;
      end
      if (poke > 0 && n == poke + 1) mif.start = 1'b0;
      #1;
      if (mif.out_valid === 1'b1) begin
        lat = n;
        res = mif.result;
        if (mif.stall !== 1'b0 || mif.busy !== 1'b0) hs_ok = 1'b0;
        break;
      end else if (mif.stall !== 1'b1 || mif.busy !== 1'b1) begin
        hs_ok = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    bit          hs_ok;
    bit          seen;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, FULL};
    vecs[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL};
    vecs[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL};
    vecs[3]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[4]  = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[5]  = '{F3_DIVU,   32'd10,       32'd0,        32'hFFFFFFFF, 1};
    vecs[6]  = '{F3_REMU,   32'd10,       32'd0,        32'd10,       1};
    vecs[7]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, FULL};
    vecs[8]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, FULL};
    vecs[9]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        FULL};
    vecs[10] = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, FULL};
    vecs[11] = '{F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1};
    vecs[12] = '{F3_MUL,    32'd0,        32'd5,        32'd0,        EL};
    vecs[13] = '{F3_DIVU,   32'd3,        32'd9,        32'd0,        EL};
    vecs[14] = '{F3_REM,    32'hFFFFFFFD, 32'd9,        32'hFFFFFFFD, EL};
    vecs[15] = '{F3_DIV,    32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, FULL};
    vecs[16] = '{F3_REM,    32'd5,        32'hFFFFFFFD, 32'd2,        FULL};
    vecs[17] = '{F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, FULL};

    // ---------------- reset state ----------------
    rst_n        = 1'b0;
    mif.start    = 1'b0;
    mif.flush    = 1'b0;
    mif.funct3   = 3'd0;
    mif.operand1 = '0;
    mif.operand2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy",      32'(mif.busy),      32'd0);
    chk("reset_stall",     32'(mif.stall),     32'd0);
    chk("reset_out_valid", 32'(mif.out_valid), 32'd0);
    chk("reset_result",    mif.result,         32'd0);
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, 0, res, lat, hs_ok);
      chk($sformatf("vec%0d_result", i),    res,         vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i),   32'(lat),    32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_handshake", i), 32'(hs_ok),  32'd1);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_pulse_width", i), 32'(mif.out_valid), 32'd0);
    end

    // ---------------- start while busy is ignored ----------------
    run_op(F3_DIVU, 32'd100, 32'd7, 1'b0, 5, res, lat, hs_ok);
    chk("busy_start_result",  res,      32'd14);
    chk("busy_start_latency", 32'(lat), 32'(FULL));
    @(negedge clk); #1;
    chk("busy_start_no_requeue", 32'(mif.busy | mif.out_valid), 32'd0);

    // ---------------- start and flush together ----------------
    @(negedge clk);
    mif.start = 1'b1; mif.flush = 1'b1;
    mif.funct3 = F3_MUL; mif.operand1 = 32'd3; mif.operand2 = 32'd4;
    #1;
    chk("start_flush_stall", 32'(mif.stall), 32'd0);
    @(negedge clk);
    mif.start = 1'b0; mif.flush = 1'b0;
    #1;
    chk("start_flush_busy", 32'(mif.busy), 32'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); #1; if (mif.out_valid === 1'b1) seen = 1'b1; end
    chk("start_flush_no_valid", 32'(seen), 32'd0);

    // ---------------- flush at cycle 10 of a DIV ----------------
    prev = mif.result;
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = F3_DIV; mif.operand1 = 32'd100; mif.operand2 = 32'd3;
    seen = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1)  mif.start = 1'b0;
      if (n == 10) mif.flush = 1'b1;
      if (n == 11) mif.flush = 1'b0;
      #1;
      if (mif.out_valid === 1'b1) seen = 1'b1;
      if (n == 10) chk("flush_busy_before", 32'(mif.busy), 32'd1);
    end
    chk("flush_idle_busy",   32'(mif.busy), 32'd0);
    chk("flush_no_valid",    32'(seen),     32'd0);
    chk("flush_result_kept", mif.result,    prev);
    run_op(F3_DIVU, 32'd1000, 32'd7, 1'b1, 0, res, lat, hs_ok);
    chk("post_flush_result",  res,      32'd142);
    chk("post_flush_latency", 32'(lat), 32'(FULL));

    // ---------------- reset pulse mid-operation ----------------
    @(negedge clk);
    mif.start = 1'b1; mif.funct3 = F3_MUL; mif.operand1 = 32'd7; mif.operand2 = 32'd9;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) mif.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        {29'd0, mif.busy, mif.stall, mif.out_valid}, 32'd0);
    chk("midreset_result", mif.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); #1; if (mif.out_valid === 1'b1 || mif.busy === 1'b1) seen = 1'b1; end
    chk("midreset_no_pulse", 32'(seen), 32'd0);

    // ---------------- randomized ops vs reference model ----------------
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_op(f3, a, b, 1'b0, 0, res, lat, hs_ok);
      chk($sformatf("rand%0d_f%0d_%h_%h_result", i, f3, a, b), res, ref_md(f3, a, b));
      chk($sformatf("rand%0d_f%0d_%h_%h_latency", i, f3, a, b), 32'(lat), 32'(ref_lat(f3, a, b)));
      chk($sformatf("rand%0d_handshake", i), 32'(hs_ok), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
